// File: rtl/approx_mult_error_profiler.sv
// Exhaustive error profiler for approximate multipliers: sweeps every (A,B) pair,
// compares approximate vs exact products and accumulates error statistics.
// Latency: N = 2^(2W) sweep cycles + LAT drain cycles, then a one-cycle done pulse.
// Backpressure: none; one operand pair per cycle, start is ignored unless idle.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start                    begin a sweep (honoured only while idle)
//   A, B                     operands driven to both multiplier instances
//   S_approx, S_exact        products returned LAT cycles after the operands
//   busy, done               sweep/drain in progress; results-final pulse
//   err_count .. max_err_B   accumulated error statistics
module approx_mult_error_profiler #(
  parameter int W   = 8,
  parameter int LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     A,
  output logic [W-1:0]     B,
  input  logic [2*W-1:0]   S_approx,
  input  logic [2*W-1:0]   S_exact,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     err_count,
  output logic [4*W:0]     sum_abs_err,
  output logic [4*W+1:0]   sum_signed_err,
  output logic [2*W-1:0]   max_abs_err,
  output logic [W-1:0]     max_err_A,
  output logic [W-1:0]     max_err_B
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

  localparam logic [2:0] DRAIN_LAST = 3'((LAT > 0) ? LAT - 1 : 0);

  state_e         state_q, state_d;
  logic [2*W-1:0] cnt_q, cnt_d;
  logic [2:0]     drain_q, drain_d;
  logic           last_pair;

  // Operand counter: low half is A (inner), high half is B (outer).
  assign last_pair = (cnt_q == '1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    drain_d = '0;
    case (state_q)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;  // wraps to 0 after the last pair
        if (last_pair) state_d = (LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q == SWEEP) || (state_q == DRAIN);
    done = (state_q == DONE);
    A    = (state_q == SWEEP) ? cnt_q[W-1:0]   : '0;
    B    = (state_q == SWEEP) ? cnt_q[2*W-1:W] : '0;
  end

  // ---------------- Sample tag pipeline ----------------
  // The tag that reaches the capture point matches the product currently on S_*.
  logic         cap_vld;
  logic [W-1:0] cap_a, cap_b;

  generate
    if (LAT == 0) begin : g_comb
      always_comb begin
        cap_vld = (state_q == SWEEP);
        cap_a   = A;
        cap_b   = B;
      end
    end else begin : g_pipe
      logic [LAT-1:0] vld_q;
      logic [W-1:0]   a_q [LAT];
      logic [W-1:0]   b_q [LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= (state_q == SWEEP);
          a_q[0]   <= A;
          b_q[0]   <= B;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            a_q[i]   <= a_q[i-1];
            b_q[i]   <= b_q[i-1];
          end
        end
      end

      always_comb begin
        cap_vld = vld_q[LAT-1];
        cap_a   = a_q[LAT-1];
        cap_b   = b_q[LAT-1];
      end
    end
  endgenerate

  // ---------------- Error datapath ----------------
  logic signed [2*W:0] err;
  logic [2*W-1:0]      abs_err;

  assign err     = $signed({1'b0, S_approx}) - $signed({1'b0, S_exact});
  // Subtract in the direction that cannot underflow, so |e| stays 2W bits.
  assign abs_err = err[2*W] ? (S_exact - S_approx) : (S_approx - S_exact);

  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start)) begin
      err_count      <= '0;
      sum_abs_err    <= '0;
      sum_signed_err <= '0;
      max_abs_err    <= '0;
      max_err_A      <= '0;
      max_err_B      <= '0;
    end else if (cap_vld) begin
      if (S_approx != S_exact) err_count <= err_count + 1'b1;
      sum_abs_err    <= sum_abs_err + {{(2*W+1){1'b0}}, abs_err};
      sum_signed_err <= sum_signed_err + {{(2*W+1){err[2*W]}}, err};
      // Strictly greater: ties keep the earliest sample in sweep order.
      if (abs_err > max_abs_err) begin
        max_abs_err <= abs_err;
        max_err_A   <= cap_a;
        max_err_B   <= cap_b;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_error_profiler.sv
module tb_approx_mult_error_profiler;

  logic clk = 1'b0;
  logic rst, start0, start1, start2;
  int   mode;

  always #5 clk = ~clk;

  // dut0: W=2 LAT=0, dut1: W=2 LAT=2, dut2: W=8 LAT=1
  logic [1:0]  a0, b0, ma0, mb0;
  logic [3:0]  sa0, se0, mx0;
  logic        busy0, done0;
  logic [4:0]  ec0;
  logic [8:0]  sabs0;
  logic [9:0]  ssg0;

  logic [1:0]  a1, b1, ma1, mb1;
  logic [3:0]  sa1, se1, mx1;
  logic        busy1, done1;
  logic [4:0]  ec1;
  logic [8:0]  sabs1;
  logic [9:0]  ssg1;
  logic [3:0]  p1_q0, p1_q1;

  logic [7:0]  a2, b2, ma2, mb2;
  logic [15:0] sa2, se2, mx2;
  logic        busy2, done2;
  logic [16:0] ec2;
  logic [32:0] sabs2;
  logic [33:0] ssg2;

  approx_mult_error_profiler #(.W(2), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0),
    .S_approx(sa0), .S_exact(se0), .busy(busy0), .done(done0),
    .err_count(ec0), .sum_abs_err(sabs0), .sum_signed_err(ssg0),
    .max_abs_err(mx0), .max_err_A(ma0), .max_err_B(mb0));

  approx_mult_error_profiler #(.W(2), .LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
    .S_approx(sa1), .S_exact(se1), .busy(busy1), .done(done1),
    .err_count(ec1), .sum_abs_err(sabs1), .sum_signed_err(ssg1),
    .max_abs_err(mx1), .max_err_A(ma1), .max_err_B(mb1));

  approx_mult_error_profiler #(.W(8), .LAT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
    .S_approx(sa2), .S_exact(se2), .busy(busy2), .done(done2),
    .err_count(ec2), .sum_abs_err(sabs2), .sum_signed_err(ssg2),
    .max_abs_err(mx2), .max_err_A(ma2), .max_err_B(mb2));

  // Multiplier stubs. mode 1 = approximate product has bit0 forced to 0.
  always_comb begin
    se0 = {2'b00, a0} * {2'b00, b0};
    sa0 = (mode == 1) ? (se0 & 4'hE) : se0;
  end

  always_ff @(posedge clk) begin
    p1_q0 <= {2'b00, a1} * {2'b00, b1};
    p1_q1 <= p1_q0;
  end
  always_comb begin
    se1 = p1_q1;
    sa1 = (mode == 1) ? (se1 & 4'hE) : se1;
  end

  always_ff @(posedge clk) begin
    se2 <= {8'd0, a2} * {8'd0, b2};
    sa2 <= {8'd0, a2} * {8'd0, b2} +
           ((a2 == 8'd255 && b2 == 8'd255) ? 16'd300 :
            (a2 == 8'd3   && b2 == 8'd7)   ? 16'd5   : 16'd0);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic read_res(input int d, output longint ec, output longint sa,
                          output longint ss, output longint mx, output longint ma,
                          output longint mb, output logic bz, output logic dn);
    case (d)
      0: begin
        ec = longint'(ec0); sa = longint'(sabs0); ss = longint'($signed(ssg0));
        mx = longint'(mx0); ma = longint'(ma0); mb = longint'(mb0);
        bz = busy0; dn = done0;
      end
      1: begin
        ec = longint'(ec1); sa = longint'(sabs1); ss = longint'($signed(ssg1));
        mx = longint'(mx1); ma = longint'(ma1); mb = longint'(mb1);
        bz = busy1; dn = done1;
      end
      default: begin
        ec = longint'(ec2); sa = longint'(sabs2); ss = longint'($signed(ssg2));
        mx = longint'(mx2); ma = longint'(ma2); mb = longint'(mb2);
        bz = busy2; dn = done2;
      end
    endcase
  endtask

  // Pulses start, then follows the sweep cycle by cycle (cycle 0 = first cycle
  // after start is sampled). Optionally re-pulses start at cycle pulse_at.
  // Returns at the negedge of the done cycle, or after the cycle budget.
  task automatic run_sweep(input int d, input int pulse_at, output int done_cyc,
                           output int busy_cnt, output int busy_at_done);
    longint ec, sa, ss, mx, ma, mb;
    logic   bz, dn;
    int     cyc;
    @(negedge clk);
    set_start(d, 1'b1);
    @(negedge clk);
    cyc          = 0;
    done_cyc     = -1;
    busy_cnt     = 0;
    busy_at_done = -1;
    while (cyc < 70000) begin
      set_start(d, (cyc == pulse_at));
      read_res(d, ec, sa, ss, mx, ma, mb, bz, dn);
      if (dn) begin
        done_cyc     = cyc;
        busy_at_done = int'(bz);
        break;
      end
      if (bz) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    set_start(d, 1'b0);
  endtask

  typedef struct {
    int     d;
    int     mode;
    int     pulse_at;
    int     exp_done;
    longint ec, sa, ss, mx, ma, mb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    longint ec, sa, ss, mx, ma, mb;
    logic   bz, dn;
    int     done_cyc, busy_cnt, busy_at_done, done_seen;

    //        dut mode pulse done  ec  sabs  ssum  max  mA   mB
    vecs[0] = '{0, 0, -1, 16,      0,  0,    0,    0,   0,   0};
    vecs[1] = '{0, 1,  5, 16,      4,  4,   -4,    1,   1,   1};   // re-start ignored
    vecs[2] = '{0, 0, -1, 16,      0,  0,    0,    0,   0,   0};   // clears prior sweep
    vecs[3] = '{1, 1, -1, 18,      4,  4,   -4,    1,   1,   1};
    vecs[4] = '{2, 0, -1, 65537,   2,  305, 305,   300, 255, 255};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 3; d++) begin
      read_res(d, ec, sa, ss, mx, ma, mb, bz, dn);
      check($sformatf("rst d%0d busy", d), longint'(bz), 0);
      check($sformatf("rst d%0d done", d), longint'(dn), 0);
      check($sformatf("rst d%0d results", d), ec | sa | ss | mx | ma | mb, 0);
    end
    check("rst d0 A", longint'(a0), 0);
    check("rst d2 B", longint'(b2), 0);

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      run_sweep(vecs[i].d, vecs[i].pulse_at, done_cyc, busy_cnt, busy_at_done);
      read_res(vecs[i].d, ec, sa, ss, mx, ma, mb, bz, dn);
      check($sformatf("v%0d done_cycle", i), done_cyc, vecs[i].exp_done);
      check($sformatf("v%0d busy_cycles", i), busy_cnt, vecs[i].exp_done);
      check($sformatf("v%0d busy_at_done", i), busy_at_done, 0);
      check($sformatf("v%0d err_count", i), ec, vecs[i].ec);
      check($sformatf("v%0d sum_abs_err", i), sa, vecs[i].sa);
      check($sformatf("v%0d sum_signed_err", i), ss, vecs[i].ss);
      check($sformatf("v%0d max_abs_err", i), mx, vecs[i].mx);
      check($sformatf("v%0d max_err_A", i), ma, vecs[i].ma);
      check($sformatf("v%0d max_err_B", i), mb, vecs[i].mb);
    end

    // Mid-sweep reset on dut0 with the bit0-dropping stub.
    mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int cyc = 0; cyc <= 9; cyc++) begin
      if (cyc == 5) check("mid ec@5", longint'(ec0), 0);
      if (cyc == 6) check("mid ec@6", longint'(ec0), 1);
      if (cyc == 9) begin
        check("mid ec@9", longint'(ec0), 2);
        check("mid A@9", longint'(a0), 1);
        check("mid B@9", longint'(b0), 2);
        check("mid busy@9", longint'(busy0), 1);
      end
      if (cyc < 9) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    read_res(0, ec, sa, ss, mx, ma, mb, bz, dn);
    check("post-rst busy", longint'(bz), 0);
    check("post-rst done", longint'(dn), 0);
    check("post-rst A", longint'(a0), 0);
    check("post-rst err_count", ec, 0);
    check("post-rst sums", sa | ss, 0);
    check("post-rst max", mx | ma | mb, 0);
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (done0 || busy0) done_seen++;
      @(negedge clk);
    end
    check("post-rst stays idle", done_seen, 0);

    run_sweep(0, -1, done_cyc, busy_cnt, busy_at_done);
    read_res(0, ec, sa, ss, mx, ma, mb, bz, dn);
    check("rerun done_cycle", done_cyc, 16);
    check("rerun err_count", ec, 4);
    check("rerun sum_signed_err", ss, -4);

    // Done is a single pulse and results hold while idle.
    repeat (3) @(negedge clk);
    read_res(0, ec, sa, ss, mx, ma, mb, bz, dn);
    check("hold done low", longint'(dn), 0);
    check("hold err_count", ec, 4);
    check("hold max_err_B", mb, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
